// File: rtl/spi_prog_bridge.sv
// SPI mode-0 boot programmer: loads imem over SPI, then becomes a byte echo link to the core.
// Optional imem readback (opcode 0xC9) is built when SPI_PROG_READBACK_EN is defined.
`timescale 1ns/1ps
module spi_prog_bridge #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  cs,
    input  logic                  mosi,
    output logic                  miso,
    output logic [7:0]            rx_data,
    output logic                  rx_valid,
    input  logic [7:0]            tx_data,
    input  logic                  tx_valid,
    output logic                  mode,
    output logic                  cmd_error,
    output logic                  cpu_rst_n,
    output logic                  imem_wr_en,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    output logic                  imem_rd_en,
    input  logic [DATA_WIDTH-1:0] imem_rdata
);
    localparam int WB = DATA_WIDTH / 8;
    localparam int AB = (ADDR_WIDTH + 7) / 8;
    localparam logic [2:0] LAST_W = 3'(WB - 1);
    localparam logic [2:0] LAST_A = 3'(AB - 1);

    typedef enum logic [2:0] {
        IDLE, ARG_DATA, ARG_ADDR, ARG_DUMMY, BURST_CNT, BURST_DATA, READ_OUT, ECHO
    } state_t;

    state_t state, state_nxt;

    logic [1:0] sclk_sy, cs_sy, mosi_sy;
    logic       sclk_q, cs_q;
    logic       sclk_rise, sclk_fall, cs_rise, cs_act;
    logic [2:0] bit_cnt;
    logic [6:0] rx_sh;
    logic       byte_done;
    logic [7:0] rx_byte;
    logic [7:0] op;
    logic [2:0] byte_idx;
    logic [8:0] words_left;
    logic       addr_inc;
    logic       op_known;
    logic [DATA_WIDTH-1:0] tx_sh;
    logic [7:0] pend;
    logic       pend_v;
    logic       boundary, load_echo, rd_capture;
    logic [7:0] load_byte;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sy <= 2'b00;
            cs_sy   <= 2'b11;
            mosi_sy <= 2'b00;
            sclk_q  <= 1'b0;
            cs_q    <= 1'b1;
        end else begin
            sclk_sy <= {sclk_sy[0], sclk};
            cs_sy   <= {cs_sy[0], cs};
            mosi_sy <= {mosi_sy[0], mosi};
            sclk_q  <= sclk_sy[1];
            cs_q    <= cs_sy[1];
        end
    end

    assign sclk_rise = sclk_sy[1] & ~sclk_q;
    assign sclk_fall = ~sclk_sy[1] & sclk_q;
    assign cs_rise   = cs_sy[1] & ~cs_q;
    assign cs_act    = ~cs_sy[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt   <= 3'd0;
            rx_sh     <= 7'd0;
            byte_done <= 1'b0;
            rx_byte   <= 8'd0;
        end else begin
            byte_done <= 1'b0;
            if (!cs_act) begin
                bit_cnt <= 3'd0;
            end else if (sclk_rise) begin
                rx_sh   <= {rx_sh[5:0], mosi_sy[1]};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_done <= 1'b1;
                    rx_byte   <= {rx_sh, mosi_sy[1]};
                end
            end
        end
    end

    always_comb begin
        op_known = 1'b0;
        case (rx_byte)
            8'hC0, 8'hC4, 8'hC5, 8'hC6, 8'hC7, 8'hC8: op_known = 1'b1;
`ifdef SPI_PROG_READBACK_EN
            8'hC9: op_known = 1'b1;
`endif
            default: op_known = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // A cs rise in the same cycle as byte_done wins: the byte is discarded.
    always_comb begin
        state_nxt = state;
        if (cs_rise) begin
            if (state != ECHO) state_nxt = IDLE;
        end else if (byte_done) begin
            case (state)
                IDLE: begin
                    case (rx_byte)
                        8'hC0: state_nxt = ARG_DATA;
                        8'hC4: state_nxt = ARG_ADDR;
                        8'hC5, 8'hC6, 8'hC7: state_nxt = ARG_DUMMY;
                        8'hC8: state_nxt = BURST_CNT;
`ifdef SPI_PROG_READBACK_EN
                        8'hC9: state_nxt = READ_OUT;
`endif
                        default: state_nxt = IDLE;
                    endcase
                end
                ARG_DATA:   if (byte_idx == LAST_W) state_nxt = IDLE;
                ARG_ADDR:   if (byte_idx == LAST_A) state_nxt = IDLE;
                ARG_DUMMY: begin
                    if (op == 8'hC6) state_nxt = ECHO;
                    else             state_nxt = IDLE;
                end
                BURST_CNT:  state_nxt = BURST_DATA;
                BURST_DATA: if (byte_idx == LAST_W && words_left == 9'd1) state_nxt = IDLE;
                READ_OUT:   if (byte_idx == LAST_W) state_nxt = IDLE;
                default:    state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op         <= 8'd0;
            byte_idx   <= 3'd0;
            words_left <= 9'd0;
            addr_inc   <= 1'b0;
            imem_wr_en <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cmd_error  <= 1'b0;
            mode       <= 1'b0;
            cpu_rst_n  <= 1'b0;
            rx_data    <= 8'd0;
            rx_valid   <= 1'b0;
        end else begin
            imem_wr_en <= 1'b0;
            rx_valid   <= 1'b0;
            addr_inc   <= 1'b0;
            if (addr_inc) imem_addr <= imem_addr + ADDR_WIDTH'(1);
            if (cs_rise) begin
                cmd_error <= 1'b0;
            end else if (byte_done) begin
                case (state)
                    IDLE: begin
                        op       <= rx_byte;
                        byte_idx <= 3'd0;
                        if (!op_known) cmd_error <= 1'b1;
                    end
                    ARG_DATA, BURST_DATA: begin
                        imem_wdata <= DATA_WIDTH'({imem_wdata, rx_byte});
                        byte_idx   <= (byte_idx == LAST_W) ? 3'd0 : byte_idx + 3'd1;
                        if (state == BURST_DATA && byte_idx == LAST_W) begin
                            imem_wr_en <= 1'b1;
                            addr_inc   <= 1'b1;
                            words_left <= words_left - 9'd1;
                        end
                    end
                    ARG_ADDR: begin
                        imem_addr <= ADDR_WIDTH'({imem_addr, rx_byte});
                        byte_idx  <= (byte_idx == LAST_A) ? 3'd0 : byte_idx + 3'd1;
                    end
                    ARG_DUMMY: begin
                        if (op == 8'hC5) imem_wr_en <= 1'b1;
                        if (op == 8'hC6) begin
                            mode      <= 1'b1;
                            cpu_rst_n <= 1'b1;
                        end
                    end
                    BURST_CNT: begin
                        words_left <= {rx_byte == 8'h00, rx_byte};
                        byte_idx   <= 3'd0;
                    end
                    READ_OUT: begin
                        byte_idx <= (byte_idx == LAST_W) ? 3'd0 : byte_idx + 3'd1;
                        if (byte_idx == LAST_W) imem_addr <= imem_addr + ADDR_WIDTH'(1);
                    end
                    ECHO: begin
                        rx_data  <= rx_byte;
                        rx_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef SPI_PROG_READBACK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_rd_en <= 1'b0;
            rd_capture <= 1'b0;
        end else begin
            imem_rd_en <= byte_done && !cs_rise && state == IDLE && rx_byte == 8'hC9;
            rd_capture <= imem_rd_en;
        end
    end
`else
    logic unused_rdata;
    assign unused_rdata = ^imem_rdata;
    assign imem_rd_en   = 1'b0;
    assign rd_capture   = 1'b0;
`endif

    // The fall right after a byte's 8th rise presents the next byte's MSB.
    assign boundary  = (bit_cnt == 3'd0);
    assign load_byte = (state == ECHO && pend_v) ? pend : 8'h00;
    assign load_echo = cs_act && !rd_capture && sclk_fall && boundary && state == ECHO && pend_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miso   <= 1'b0;
            tx_sh  <= '0;
            pend   <= 8'd0;
            pend_v <= 1'b0;
        end else begin
            if (tx_valid) begin
                pend   <= tx_data;
                pend_v <= 1'b1;
            end else if (load_echo) begin
                pend_v <= 1'b0;
            end
            if (!cs_act) begin
                miso  <= 1'b0;
                tx_sh <= '0;
            end else if (rd_capture) begin
                tx_sh <= imem_rdata;
            end else if (sclk_fall) begin
                if (boundary && state != READ_OUT) begin
                    miso  <= load_byte[7];
                    tx_sh <= {load_byte[6:0], {(DATA_WIDTH-7){1'b0}}};
                end else begin
                    miso  <= tx_sh[DATA_WIDTH-1];
                    tx_sh <= tx_sh << 1;
                end
            end
        end
    end
endmodule

// File: doc/spi_prog_bridge.md
# spi_prog_bridge

- SPI mode-0 slave that boots the RISC-V core: it loads instruction memory over SPI, then hands the link to the core as a byte echo channel.
- Parametrised successor of the fixed 32-bit / 16-word programmer:
  - generic data width and address width;
  - auto-incrementing burst writes;
  - optional instruction-memory readback.
- Sits between the chip SPI pins and the imem write/read port, and owns `cpu_rst_n`.

## Interface
Parameters:
- DATA_WIDTH, 32, instruction word width; multiple of 8, range 8–64.
- ADDR_WIDTH, 4, imem address width, 1–16.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- sclk, cs, mosi  in  1 each  SPI pins; asynchronous to clk; cs active low.
- miso  out  1  SPI data out.
- rx_data  out  8  echo-mode received byte.
- rx_valid  out  1  one-cycle strobe, rx_data valid.
- tx_data  in  8  echo-mode byte to send.
- tx_valid  in  1  one-cycle strobe, captures tx_data.
- mode  out  1  0 = boot, 1 = echo.
- cmd_error  out  1  sticky unknown-opcode flag.
- cpu_rst_n  out  1  core reset, low while in boot mode.
- imem_wr_en  out  1  one-cycle write strobe.
- imem_addr  out  ADDR_WIDTH  imem address.
- imem_wdata  out  DATA_WIDTH  write data.
- imem_rd_en  out  1  one-cycle read strobe.
- imem_rdata  in  DATA_WIDTH  read data, valid one clk after imem_rd_en.

## Operation
- **Input sampling:** sclk, cs and mosi each pass through a 2-FF synchroniser, then edge-detect.
  - mosi is sampled on sclk rise; miso changes on sclk fall. Both are MSB first.
  - 8 rises form one byte.
  - cs high clears the bit counter and discards any partial byte.
- **Derived constants:** WB = DATA_WIDTH/8; AB = ceil(ADDR_WIDTH/8).
- **Boot-mode opcodes** (every byte is first interpreted in state IDLE):
  - 0xC0 LOAD_DATA: next WB bytes shift into imem_wdata, MSB first.
  - 0xC4 LOAD_ADDR: next AB bytes load imem_addr, MSB first; bits above ADDR_WIDTH are dropped.
  - 0xC5 WRITE_IMEM: one dummy byte follows; at its completion imem_wr_en pulses with the current addr and data. Address is unchanged.
  - 0xC6 MODE_ECHO: one dummy byte follows; at its completion mode←1 and cpu_rst_n←1.
  - 0xC7 MODE_BOOT: one dummy byte follows; no-op in boot mode.
  - 0xC8 WRITE_BURST: count byte N follows (0 means 256), then N×WB bytes.
    - After each full word, imem_wr_en pulses.
    - imem_addr increments on the cycle after each pulse, wrapping modulo 2^ADDR_WIDTH.
  - 0xC9 READ_IMEM (only with SPI_PROG_READBACK_EN):
    - imem_rd_en pulses on the cycle after the opcode completes.
    - imem_rdata is captured the next cycle into the tx shifter.
    - The next WB dummy bytes shift it out on miso; imem_addr then increments, with wrap.
  - Any other opcode: cmd_error←1; byte dropped; state stays IDLE.
- **FSM states:** IDLE, ARG_DATA, ARG_ADDR, ARG_DUMMY, BURST_CNT, BURST_DATA, READ_OUT, ECHO.
  - Argument states count bytes and return to IDLE; the last MODE_ECHO byte goes to ECHO instead.
- **Echo mode** is sticky until rst, and all opcodes are ignored.
  - Each received byte gives one rx_valid pulse with rx_data.
  - tx_valid captures tx_data into a pending register; a later tx_valid before load overwrites it.
  - Pending data loads into the shifter at the first sclk fall of the next byte and is then cleared.
  - With nothing pending, 0x00 is sent.
- **Default miso:** in boot mode, miso sends 0x00 except during READ_OUT.
- **cs deassert mid-command:** FSM returns to IDLE (or stays ECHO); no write is issued; already-loaded imem_wdata/imem_addr bytes are kept; cmd_error clears.
- **Simultaneous events:** a cs rise and a byte completion in the same cycle count as a deselect; the byte is discarded.

## Timing
- **Reset values:** miso 0, rx_data 0, rx_valid 0, mode 0, cmd_error 0, cpu_rst_n 0, imem_wr_en 0, imem_addr 0, imem_wdata 0, imem_rd_en 0. FSM goes to IDLE and the tx pending flag clears.
- **rst mid-operation:** aborts immediately with no strobe.
- **Byte-complete latency:** 3 clk from the 8th sclk rise at the pin (2 sync + 1 edge detect).
- **Strobe timing:** imem_wr_en, rx_valid and mode change register one clk after byte-complete.
- **sclk high and low phases** must each be ≥ 4 clk; this guarantees readback data is in the shifter before the first fall.
- **cmd_error** clears only on rst or a cs rise.

## Configuration
- SPI_PROG_READBACK_EN defined:
  - 0xC9 is decoded as above;
  - the READ_OUT state and imem_rd_en logic exist.
- Undefined:
  - 0xC9 is treated as an unknown opcode (sets cmd_error);
  - imem_rd_en is tied 0;
  - imem_rdata is unused.

## Test plan
All scenarios use DATA_WIDTH=32, ADDR_WIDTH=4.
1. C0 AA BB CC DD, C4 09, C5 66 -> exactly one imem_wr_en pulse with imem_addr=9 and imem_wdata=AABBCCDD; cpu_rst_n stays 0.
2. C4 0E, C8 03, then words 11111111 22222222 33333333 -> writes to addresses E, F, 0 (wrap) with those words; final imem_addr=1.
3. 5A -> cmd_error=1 and no strobes; then cs high -> cmd_error=0; then C4 03 -> imem_addr=3.
4. C6 66 -> mode=1 and cpu_rst_n=1; host sends A5 while tx_data=0F with tx_valid pulsed -> rx_valid pulse with rx_data=A5, and the next byte on miso is 0F; the following byte is 00.
5. With the macro defined, after scenario 1: C4 09, C9, 4 dummy bytes -> miso reads AABBCCDD and imem_addr=A. Without the macro: C9 sets cmd_error, and miso reads 00.
6. Assert rst after C8 02 plus 2 data bytes -> all outputs at reset values, no imem_wr_en; after release, scenario 1 passes.
